// File: rtl/instruction_issue.sv
// Program sequencer feeding the instruction decoder.
// Fetches 64-bit words from a 1-cycle-latency instruction RAM and issues each
// one with a single-cycle instr_enable strobe. After issuing, it may block on
// the completion pulse for the opcode's class, stop at end-of-program (8'h82),
// or pause at a verification hold (8'h44).
//
// Handshake semantics: fetch_done, compute_done and resume are single-cycle
// pulses with no ready/acknowledge. Each is sampled only in the state that
// waits for it (WAIT_DONE for the selected done, HOLD for resume) and is
// ignored and forgotten in every other cycle. start is likewise a pulse,
// accepted only in IDLE or HALT. instr_enable is a valid-only strobe: the
// decoder must take the instruction in the cycle it is high.
module instruction_issue #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [63:0]       imem_rdata,
  output logic [63:0]       instruction,
  output logic              instr_enable,
  input  logic              fetch_done,
  input  logic              compute_done,
  input  logic              resume,
  output logic              busy,
  output logic              hold,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       issue_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_HOLD      = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  // Wide enough to hold TIMEOUT-1.
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [63:0]       r_instr;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_count;
  logic              r_error;
  logic [TW-1:0]     r_timer;
  logic              r_wait_compute;

  logic [7:0]        w_opcode;
  logic              w_done;
  logic              w_timeout;
  logic              w_start_ok;
  logic              w_expire;

  assign w_opcode   = r_instr[63:56];
  // Only the done pulse matching the issued opcode class is honoured.
  assign w_done     = r_wait_compute ? compute_done : fetch_done;
  assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_HALT));
  // Timeout fires only if done does not arrive in the same cycle.
  assign w_expire   = (r_state == S_WAIT_DONE) && !w_done && w_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = S_WAIT_DATA;
      S_WAIT_DATA:    w_next = S_ISSUE;
      S_ISSUE: begin
        case (w_opcode)
          8'h01, 8'h02, 8'h04, 8'h81: w_next = S_WAIT_DONE;
          8'h82:                      w_next = S_HALT;
          8'h44:                      w_next = S_HOLD;
          default:                    w_next = S_FETCH;
        endcase
      end
      S_WAIT_DONE: begin
        if (w_done)        w_next = S_FETCH;
        else if (w_expire) w_next = S_HALT;
      end
      S_HOLD:  if (resume) w_next = S_FETCH;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    imem_rd_en   = (r_state == S_FETCH);
    imem_addr    = (r_state == S_FETCH) ? r_pc : '0;
    instr_enable = (r_state == S_ISSUE);
    instruction  = (r_state == S_ISSUE) ? r_instr : 64'd0;
    busy         = (r_state != S_IDLE) && (r_state != S_HALT);
    hold         = (r_state == S_HOLD);
    halted       = (r_state == S_HALT);
    error        = r_error;
    pc           = r_pc;
    issue_count  = r_count;
    dbg_state    = r_state;
  end

  // Instruction register: captures RAM data the cycle after the read strobe
  always_ff @(posedge clk) begin
    if (rst)                         r_instr <= 64'd0;
    else if (r_state == S_WAIT_DATA) r_instr <= imem_rdata;
  end

  // Program counter and issue counter: loaded on start, advanced on issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_count <= 16'd0;
    end else if (w_start_ok) begin
      r_pc    <= start_addr;
      r_count <= 16'd0;
    end else if (r_state == S_ISSUE) begin
      r_pc    <= r_pc + ADDR_W'(1);
      r_count <= r_count + 16'd1;
    end
  end

  // Remember which done pulse the issued instruction waits for
  always_ff @(posedge clk) begin
    if (rst)                     r_wait_compute <= 1'b0;
    else if (r_state == S_ISSUE) r_wait_compute <= (w_opcode == 8'h81);
  end

  // Wait timer: counts cycles in WAIT_DONE, cleared on any exit
  always_ff @(posedge clk) begin
    if (rst)
      r_timer <= '0;
    else if ((r_state == S_WAIT_DONE) && !w_done && !w_timeout)
      r_timer <= r_timer + TW'(1);
    else
      r_timer <= '0;
  end

  // Sticky timeout flag, cleared by reset or an accepted start
  always_ff @(posedge clk) begin
    if (rst)             r_error <= 1'b0;
    else if (w_start_ok) r_error <= 1'b0;
    else if (w_expire)   r_error <= 1'b1;
  end

endmodule

// File: tb/tb_instruction_issue.sv
// Bench for instruction_issue: directed timing scenarios plus randomized
// programs, with a scoreboard of expected fetch addresses and issued words.
module tb_instruction_issue;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [63:0]       imem_rdata;
  logic [63:0]       instruction;
  logic              instr_enable;
  logic              fetch_done;
  logic              compute_done;
  logic              resume;
  logic              busy;
  logic              hold;
  logic              halted;
  logic              error;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       issue_count;
  logic [2:0]        dbg_state;

  // Driver-side and responder-side copies of the pulse inputs.
  logic d_start, d_fetch_done, d_compute_done, d_resume;
  logic rs_start, rs_fetch_done, rs_compute_done, rs_resume;
  logic resp_en;

  assign start        = d_start | rs_start;
  assign fetch_done   = d_fetch_done | rs_fetch_done;
  assign compute_done = d_compute_done | rs_compute_done;
  assign resume       = d_resume | rs_resume;

  logic [63:0]       mem [0:DEPTH-1];
  logic [63:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  instruction_issue #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .imem_rd_en   (imem_rd_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .instr_enable (instr_enable),
    .fetch_done   (fetch_done),
    .compute_done (compute_done),
    .resume       (resume),
    .busy         (busy),
    .hold         (hold),
    .halted       (halted),
    .error        (error),
    .pc           (pc),
    .issue_count  (issue_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Instruction RAM: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
    else            imem_rdata <= {$urandom, $urandom};
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start is sampled in "cycle 0"; returns positioned in cycle 1.
  task automatic pulse_start(input int a);
    @(posedge clk); #1;
    d_start    = 1'b1;
    start_addr = ADDR_W'(a);
    @(posedge clk); #1;
    d_start = 1'b0;
  endtask

  // Reference model: walk the program from sa, one word per issue, stopping
  // after end-of-program or after max_n issues.
  task automatic model_program(input int sa, input int max_n, output int e_pc, output int e_cnt);
    int a;
    logic [63:0] w;
    a = sa;
    e_cnt = 0;
    while (e_cnt < max_n) begin
      w = mem[a];
      exp_addr_q.push_back(ADDR_W'(a));
      exp_q.push_back(w);
      e_cnt++;
      a = (a + 1) % DEPTH;
      if (w[63:56] == 8'h82) break;
    end
    e_pc = a;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_rd_en) begin
        if (exp_addr_q.size() == 0) check("unexpected_fetch", {60'd0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else                        check("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (instr_enable) begin
        if (exp_q.size() == 0) check("unexpected_issue", instruction, 64'hFFFF_FFFF_FFFF_FFFF);
        else                   check("issued_word", instruction, exp_q.pop_front());
      end else begin
        check("instruction_zero_when_idle", instruction, 64'd0);
      end
    end
  end

  // ---------------- responder for randomized programs ----------------
  initial begin
    logic [7:0] op;
    logic       stray;
    int         d;
    rs_start = 0; rs_fetch_done = 0; rs_compute_done = 0; rs_resume = 0;
    forever begin
      @(negedge clk);
      if (resp_en && !rst && instr_enable) begin
        op    = instruction[63:56];
        d     = $urandom_range(1, 12);
        stray = 1'($urandom_range(0, 1));
        if (op inside {8'h01, 8'h02, 8'h04, 8'h81, 8'h44}) begin
          for (int c = 1; c <= d; c++) begin
            @(posedge clk); #1;
            rs_start        = (op == 8'h44) && (c == 1);
            rs_resume       = (op == 8'h44) && (c == d);
            rs_compute_done = (op == 8'h81) ? (c == d) : ((op != 8'h44) && (c == 1) && stray);
            rs_fetch_done   = (op != 8'h81 && op != 8'h44) ? (c == d) : ((op == 8'h81) && (c == 1) && stray);
          end
          @(posedge clk); #1;
          rs_start = 0; rs_fetch_done = 0; rs_compute_done = 0; rs_resume = 0;
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int e_pc, e_cnt, len, sa, k, waited;
    logic any_rd;
    logic [63:0] w;
    logic [7:0] other_ops [0:2];
    other_ops[0] = 8'h00; other_ops[1] = 8'h7F; other_ops[2] = 8'hC3;

    rst = 1; d_start = 0; d_fetch_done = 0; d_compute_done = 0; d_resume = 0;
    start_addr = '0; resp_en = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    step(3);
    check("reset_outputs", {imem_rd_en, imem_addr, instr_enable, busy, hold, halted, error, pc, issue_count, dbg_state}, 64'd0);
    check("reset_instruction", instruction, 64'd0);
    rst = 0;

    // Short program: issues at cycles 3, 6, 9 then halt.
    mem[0] = 64'h4001_0000_0000_0000;
    mem[1] = 64'h4000_0000_0000_0000;
    mem[2] = 64'h8200_0000_0000_0000;
    model_program(0, DEPTH, e_pc, e_cnt);
    pulse_start(0);
    check("short_fetch_c1", {imem_rd_en, imem_addr}, {1'b1, 4'd0});
    step(2); check("short_issue_c3", {instr_enable, instruction}, {1'b1, mem[0]});
    step(3); check("short_issue_c6", {instr_enable, instruction}, {1'b1, mem[1]});
    step(3); check("short_issue_c9", {instr_enable, instruction}, {1'b1, mem[2]});
    step(1); check("short_halt", {halted, busy, pc, issue_count}, {1'b1, 1'b0, 4'(e_pc), 16'(e_cnt)});

    // Fetch handshake with a stray compute_done.
    mem[5] = 64'h0200_0100_0003_0110;
    mem[6] = 64'h8200_0000_0000_0000;
    model_program(5, DEPTH, e_pc, e_cnt);
    pulse_start(5);
    step(2); check("fh_issue_c3", instr_enable, 1'b1);
    any_rd = 0;
    for (int c = 4; c <= 10; c++) begin
      step(1);
      if (imem_rd_en) any_rd = 1;
      d_compute_done = (c == 6);
      d_fetch_done   = (c == 10);
    end
    check("fh_no_fetch_while_waiting", any_rd, 1'b0);
    step(1); d_fetch_done = 0;
    check("fh_fetch_after_done", {imem_rd_en, imem_addr}, {1'b1, 4'd6});
    step(3); check("fh_halt", {halted, pc, issue_count}, {1'b1, 4'(e_pc), 16'(e_cnt)});

    // Timeout on a compute wait; a stray fetch_done must not end it.
    mem[0] = 64'h8100_0000_0000_0000;
    model_program(0, 1, e_pc, e_cnt);
    pulse_start(0);
    step(2);
    for (int c = 4; c <= 19; c++) begin
      step(1);
      d_fetch_done = (c == 8);
    end
    check("to_not_yet_c19", {halted, error, busy}, {1'b0, 1'b0, 1'b1});
    step(1);
    check("to_expired_c20", {halted, error, busy, pc, issue_count}, {1'b1, 1'b1, 1'b0, 4'd1, 16'd1});

    // Done on the last timeout cycle wins; start from HALT clears error.
    mem[0] = 64'h0100_0000_0000_0000;
    mem[1] = 64'h8200_0000_0000_0000;
    model_program(0, DEPTH, e_pc, e_cnt);
    pulse_start(0);
    check("restart_clears_error", {error, issue_count}, {1'b0, 16'd0});
    step(2);
    for (int c = 4; c <= 19; c++) begin
      step(1);
      d_fetch_done = (c == 19);
    end
    step(1); d_fetch_done = 0;
    check("to_done_wins", {imem_rd_en, imem_addr, error, halted}, {1'b1, 4'd1, 1'b0, 1'b0});
    step(3); check("to_done_wins_halt", {halted, error, pc, issue_count}, {1'b1, 1'b0, 4'(e_pc), 16'(e_cnt)});

    // Hold / resume with an ignored start during hold.
    mem[0] = 64'h4400_0000_0000_0000;
    mem[1] = 64'h8200_0000_0000_00AA;
    mem[9] = 64'h4000_0000_0000_0009;
    model_program(0, DEPTH, e_pc, e_cnt);
    pulse_start(0);
    step(3); check("hold_rises_c4", {hold, busy}, {1'b1, 1'b1});
    for (int c = 5; c <= 14; c++) begin
      step(1);
      d_start  = (c == 7);
      if (c == 7) start_addr = 4'd9;
      d_resume = (c == 14);
      if (c == 8) check("hold_ignores_start", {hold, pc, issue_count}, {1'b1, 4'd1, 16'd1});
    end
    check("hold_until_resume", hold, 1'b1);
    step(1); d_resume = 0;
    check("resume_fetch", {hold, imem_rd_en, imem_addr}, {1'b0, 1'b1, 4'd1});
    step(2); check("resume_issue_3_after", {instr_enable, instruction}, {1'b1, mem[1]});
    step(1); check("hold_halt", {halted, pc, issue_count}, {1'b1, 4'(e_pc), 16'(e_cnt)});

    // Address wrap.
    mem[15] = 64'h4000_0000_0000_000F;
    mem[0]  = 64'h8200_0000_0000_0000;
    model_program(15, DEPTH, e_pc, e_cnt);
    pulse_start(15);
    check("wrap_first_fetch", {imem_rd_en, imem_addr}, {1'b1, 4'd15});
    step(3); check("wrap_second_fetch", {imem_rd_en, imem_addr}, {1'b1, 4'd0});
    step(3); check("wrap_halt", {halted, pc, issue_count}, {1'b1, 4'(e_pc), 16'(e_cnt)});

    // Reset mid-wait, late done ignored, start+rst together, restart.
    mem[0] = 64'h0100_0000_0000_0000;
    mem[2] = 64'h4000_0000_0000_0002;
    mem[3] = 64'h8200_0000_0000_0003;
    model_program(0, 1, e_pc, e_cnt);
    pulse_start(0);
    step(5); rst = 1;
    step(1); rst = 0;
    check("rst_outputs", {imem_rd_en, imem_addr, instr_enable, busy, hold, halted, error, pc, issue_count, dbg_state}, 64'd0);
    check("rst_instruction", instruction, 64'd0);
    step(1); d_fetch_done = 1;
    step(1); d_fetch_done = 0;
    check("rst_late_done_ignored", {busy, imem_rd_en}, 2'b00);
    step(1); rst = 1; d_start = 1; start_addr = 4'd2;
    step(1); rst = 0; d_start = 0;
    check("rst_beats_start", {busy, pc}, {1'b0, 4'd0});
    model_program(2, DEPTH, e_pc, e_cnt);
    pulse_start(2);
    check("restart_fetch", {imem_rd_en, imem_addr}, {1'b1, 4'd2});
    step(6); check("restart_halt", {halted, pc, issue_count}, {1'b1, 4'(e_pc), 16'(e_cnt)});
    check("directed_queues_drained", exp_q.size() + exp_addr_q.size(), 0);

    // Randomized programs.
    resp_en = 1;
    for (int it = 0; it < 20; it++) begin
      len = $urandom_range(2, DEPTH);
      sa  = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < len; i++) begin
        w = {$urandom, $urandom};
        k = $urandom_range(0, 7);
        case (k)
          0: w[63:56] = 8'h01;
          1: w[63:56] = 8'h02;
          2: w[63:56] = 8'h04;
          3: w[63:56] = 8'h81;
          4: w[63:56] = 8'h40;
          5: w[63:56] = 8'h44;
          default: w[63:56] = other_ops[k - 5];
        endcase
        if (i == len - 1) w[63:56] = 8'h82;
        mem[(sa + i) % DEPTH] = w;
      end
      model_program(sa, DEPTH, e_pc, e_cnt);
      pulse_start(sa);
      waited = 0;
      while (!halted && waited < 1000) begin
        step(1);
        waited++;
      end
      check("rand_halt_reached", halted, 1'b1);
      check("rand_final", {error, pc, issue_count}, {1'b0, 4'(e_pc), 16'(e_cnt)});
      step(2);
      check("rand_queues_drained", exp_q.size() + exp_addr_q.size(), 0);
    end
    resp_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_issue.md
Name: instruction_issue

Overview:
- Program sequencer that feeds the instruction decoder.
- Reads 64-bit instructions from the instruction RAM, which has a 1-cycle read latency.
- Presents each instruction with a single-cycle instr_enable pulse.
- Blocks on the completion handshake matching the issued opcode class; stops on the end-of-program opcode 8'h82 and pauses on the verification-hold opcode 8'h44.

Parameters:
- ADDR_W, 10, instruction RAM address width (1024 words).
- TIMEOUT, 4096, maximum cycles in WAIT_DONE before the error halt.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse; begin execution at start_addr. Ignored unless in IDLE or HALT.
- start_addr  input  ADDR_W  first instruction address.
- imem_rd_en  output  1  instruction RAM read strobe.
- imem_addr  output  ADDR_W  instruction RAM read address.
- imem_rdata  input  64  RAM data, valid the cycle after imem_rd_en.
- instruction  output  64  instruction to the decoder; 0 whenever instr_enable is low.
- instr_enable  output  1  one-cycle issue strobe.
- fetch_done  input  1  pulse from the feature/weight/scaler fetchers.
- compute_done  input  1  pulse from the conv/line-buffer datapath.
- resume  input  1  pulse that releases HOLD.
- busy  output  1  high in every state except IDLE and HALT.
- hold  output  1  high in HOLD.
- halted  output  1  high in HALT.
- error  output  1  sticky timeout flag; cleared by rst or an accepted start.
- pc  output  ADDR_W  address of the next instruction to fetch.
- issue_count  output  16  instructions issued since the last accepted start; wraps at 16'hFFFF→0.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0; pc=0, issue_count=0, error=0.
  - Internal instruction register and timeout counter 0.
  - rst mid-operation aborts immediately with the same values; an in-flight RAM read is discarded.
- States: IDLE, FETCH, WAIT_DATA, ISSUE, WAIT_DONE, HOLD, HALT.
- IDLE/HALT + start:
  - pc<=start_addr, issue_count<=0, error<=0.
  - Next state FETCH.
- FETCH:
  - imem_rd_en=1, imem_addr=pc for exactly this cycle.
  - Next state WAIT_DATA.
- WAIT_DATA:
  - Latch imem_rdata into the instruction register.
  - Next state ISSUE.
- ISSUE:
  - instruction=register, instr_enable=1 for exactly one cycle.
  - pc<=pc+1, wrapping 2^ADDR_W−1→0.
  - issue_count<=issue_count+1.
  - Next state is selected by opcode = register[63:56]:
    - 8'h01, 8'h02, 8'h04 → WAIT_DONE, waiting on fetch_done.
    - 8'h81 → WAIT_DONE, waiting on compute_done.
    - 8'h82 → HALT. The instruction is still issued so the decoder raises test_exe_done.
    - 8'h44 → HOLD.
    - 8'h40 and all other opcodes → FETCH, no wait.
- Latency:
  - start sampled in cycle 0 → imem_rd_en in cycle 1 → instr_enable in cycle 3.
  - Back-to-back no-wait instructions issue every 3 cycles.
- WAIT_DONE:
  - Samples only the selected done input; the other done input is ignored.
  - Done pulses arriving outside WAIT_DONE are ignored and not remembered.
  - Done high → FETCH in the next cycle; the timeout counter clears.
  - Otherwise the counter increments. When it reaches TIMEOUT−1 without done: error<=1 and state → HALT.
  - A done arriving in the same cycle as the timeout wins: no error, next state FETCH.
- HOLD:
  - hold=1; waits for resume, then goes to FETCH.
  - start is ignored in HOLD and in every other busy state.
- HALT:
  - halted=1; pc and issue_count are held.
  - Only start or rst leaves HALT.
- start coinciding with rst: rst wins.

Test Plan:
- Short program:
  - Stimulus: RAM[0]=40_01_00.., RAM[1]=40_00.., RAM[2]=82_00..; pulse start with start_addr=0.
  - Required: instr_enable high in cycles 3, 6, 9 carrying those words; then halted=1, pc=3, issue_count=3, busy=0.
- Fetch handshake:
  - Stimulus: RAM[5]=02_00_01_00_00_03_01_10, RAM[6]=82..; start_addr=5; fetch_done pulsed 7 cycles after the issue.
  - Required: no imem_rd_en while waiting; FETCH of address 6 the cycle after fetch_done. A stray compute_done during the wait has no effect.
- Timeout:
  - Stimulus: TIMEOUT=16; RAM[0]=81..; compute_done never pulsed.
  - Required: error=1 and halted=1 exactly 16 cycles after entering WAIT_DONE; pc=1.
- Hold/resume:
  - Stimulus: RAM[0]=44.., RAM[1]=82..; resume pulsed 10 cycles after hold rises. Also pulse start during HOLD.
  - Required: hold=1 until resume; start during hold is ignored; RAM[1] issued 3 cycles after resume.
- Wrap:
  - Stimulus: ADDR_W=4; RAM[15]=40.., RAM[0]=82..; start_addr=15.
  - Required: second fetch uses imem_addr=0; halted with pc=1, issue_count=2.
- Reset mid-wait:
  - Stimulus: assert rst during WAIT_DONE of an 8'h01 instruction, then pulse start_addr=2.
  - Required: all outputs 0 the cycle after rst; a later fetch_done is ignored; the restart fetches address 2 normally.
